mvm_acc_act: RTL and testbench
==============================

Name: mvm_acc_act

Overview:
- Downstream stage of the stochastic MVM block.
- Each MVM pass ends when its busy flag falls; this block then captures the DIM up-counter results and adds them, signed by the weight sign, into per-lane accumulators.
- After NUM_TERM passes it applies bias, ReLU, right shift and saturation to NUM_BIT.
- It presents the DIM-wide activation vector on a valid/ready handshake to the next layer.

Parameters:
- NUM_BIT, 4: width of the MVM count inputs and of the activation outputs (unsigned).
- DIM, 4: number of lanes. Must match the MVM lane count.
- NUM_TERM, 4: number of MVM passes accumulated per output vector (≥1).
- SHIFT, 0: arithmetic right shift applied after ReLU (0..ACC_BIT-1).
- ACC_BIT, NUM_BIT+$clog2(NUM_TERM)+2: signed accumulator width. Derived; no overflow is possible.

Ports:
- i_clk_acc, in, 1: clock.
- i_rst_acc, in, 1: reset. One clock; reset is synchronous and active-high.
- i_ismvm, in, 1: MVM busy flag. Its 1→0 transition marks the MVM results as final.
- i_wx_result, in, [NUM_BIT-1:0] x DIM: MVM count per lane (unsigned).
- i_w_neg, in, 1: sign of the current weight. 1 means subtract. Sampled with the results.
- i_bias, in, [NUM_BIT:0] x DIM: signed per-lane bias. Sign-extended; sampled in the ACT cycle.
- i_clear, in, 1: synchronous frame abort.
- i_ready, in, 1: downstream ready.
- o_valid, out, 1: activation vector valid.
- o_y, out, [NUM_BIT-1:0] x DIM: activation vector.
- o_busy, out, 1: high in ACT and HOLD. Upstream must not finish a pass while this is high.
- o_overrun, out, 1: sticky flag; a completed MVM pass was dropped.

Behaviour:
- Reset values: all outputs 0; accumulators 0; term counter 0; ismvm_d=0; state ACCUM.
- Priority per edge: i_rst_acc > i_clear > normal operation.
- done = ismvm_d & ~i_ismvm, with ismvm_d the registered i_ismvm. A low i_ismvm after reset never produces a done.
- ACCUM state, on done:
  - acc[i] += i_w_neg ? -zext(i_wx_result[i]) : +zext(i_wx_result[i]), for all lanes in the same edge.
  - term_cnt++.
  - If term_cnt == NUM_TERM-1, term_cnt→0 and go to ACT.
- ACT state, 1 cycle:
  - s = acc[i] + sext(i_bias[i]).
  - r = (s<0) ? 0 : s>>>SHIFT.
  - o_y[i] = (r > 2^NUM_BIT-1) ? 2^NUM_BIT-1 : r[NUM_BIT-1:0].
  - Register o_y, set o_valid=1, go to HOLD.
- HOLD state:
  - o_y and o_valid are held stable.
  - On i_ready & o_valid: o_valid→0, all acc→0, go to ACCUM.
  - Ready may already be high in the first HOLD cycle. The earliest result is therefore a 1-cycle o_valid pulse.
- Latency: done seen in cycle t (first cycle i_ismvm low) → acc updated at the end of t → ACT in t+1 → o_valid high in t+2.
- done while in ACT or HOLD: the results are ignored, acc and term_cnt are unchanged, and o_overrun←1. o_overrun stays set until reset or i_clear.
- i_clear in any state: acc→0, term_cnt→0, o_valid→0, o_y→0, o_overrun→0, state ACCUM. A done in the same cycle is discarded.
- Reset mid-operation: identical to power-on reset, with no partial output.
- NUM_TERM=1: every done goes directly to ACT.
- i_wx_result is sampled only on done. It is don't-care otherwise.

Decomposition:
- Shared header/package: NUM_BIT and DIM constants (same definitions the MVM uses); typedef of state enum {ACCUM, ACT, HOLD}; function sat_relu(acc, bias, shift).
- Sub-module acc_lane, one per lane via generate loop. It holds a signed accumulator with add/sub/clear controls and combinational bias+ReLU+shift+saturate.
- The top level holds the FSM, edge detect, term counter and handshake.

Test Plan (NUM_BIT=4, DIM=4, NUM_TERM=2, SHIFT=0, bias 0 unless stated):
- Reset: assert i_rst_acc for 2 cycles with i_ismvm low → all outputs 0 and no o_valid for 10 cycles after release.
- Positive accumulation with saturation:
  - Stimulus: pass {3,5,0,15}, then pass {2,1,0,15}.
  - Response: o_valid 2 cycles after the second falling edge, o_y={5,6,0,15} (lane 3 = 30, saturated).
- Negative weight, ReLU and bias:
  - Pass A: {3,7,1,0}, w_neg=0. Pass B: {5,2,0,0}, w_neg=1. Bias {0,-1,2,0}.
  - Response: o_y={0,4,3,0}.
- Shift (SHIFT=1): passes {4,1,8,15} and {5,1,8,15} → o_y={4,1,8,15}.
- Backpressure and overrun:
  - Hold i_ready low 5 cycles in HOLD and issue one extra pass {9,9,9,9} during HOLD.
  - Response: o_y stable, o_overrun=1.
  - After ready: accumulators start from 0, and the next two passes {1,1,1,1},{1,1,1,1} give {2,2,2,2}.
- Clear mid-frame: one pass {7,7,7,7}, then i_clear, then passes {1,2,3,4},{1,2,3,4} → o_y={2,4,6,8}, o_overrun=0.

Source files
------------

// File: rtl/mvm_acc_act_pkg.sv
// Shared constants, state type and activation helper for the MVM
// accumulate/activate stage.
package mvm_acc_act_pkg;

   localparam int NUM_BIT_DEF = 4;
   localparam int DIM_DEF     = 4;
   localparam int FN_W        = 32;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      ACT   = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // bias add, ReLU, arithmetic right shift, saturate to num_bit unsigned
   function automatic logic [FN_W-1:0] sat_relu(
      input logic signed [FN_W-1:0] acc,
      input logic signed [FN_W-1:0] bias,
      input int unsigned            shift,
      input int unsigned            num_bit
   );
      logic signed [FN_W-1:0] sum_v;
      logic signed [FN_W-1:0] rel_v;
      logic signed [FN_W-1:0] max_v;
      sum_v = acc + bias;
      max_v = (32'sd1 <<< num_bit) - 32'sd1;
      if (sum_v < 32'sd0) begin
         rel_v = 32'sd0;
      end else begin
         rel_v = sum_v >>> shift;
      end
      if (rel_v > max_v) begin
         sat_relu = max_v;
      end else begin
         sat_relu = rel_v;
      end
   endfunction

endpackage

// File: rtl/mvm_acc_act_acc_lane.sv
// One lane: signed accumulator with add/sub/clear plus the combinational
// bias + ReLU + shift + saturate path feeding the output register.
module mvm_acc_act_acc_lane
   import mvm_acc_act_pkg::*;
#(
   parameter int NUM_BIT = NUM_BIT_DEF,
   parameter int ACC_BIT = NUM_BIT_DEF + 4,
   parameter int SHIFT   = 0
) (
   input  logic               i_clk_acc,
   input  logic               i_rst_acc,
   input  logic               i_add,
   input  logic               i_sub,
   input  logic               i_clr,
   input  logic [NUM_BIT-1:0] i_val,
   input  logic [NUM_BIT:0]   i_bias,
   output logic [NUM_BIT-1:0] o_act
);

   logic signed [ACC_BIT-1:0] acc_r;
   logic signed [ACC_BIT-1:0] val_ext_s;
   logic signed [FN_W-1:0]    acc_wide_s;
   logic signed [FN_W-1:0]    bias_wide_s;
   logic [FN_W-1:0]           act_wide_s;
   logic                      unused_hi_s;

   // MVM counts are unsigned, so zero-extend before add/sub
   assign val_ext_s = {{(ACC_BIT-NUM_BIT){1'b0}}, i_val};

   // accumulator register; clear wins over any update in the same cycle
   always_ff @(posedge i_clk_acc) begin
      if (i_rst_acc) begin
         acc_r <= '0;
      end else if (i_clr) begin
         acc_r <= '0;
      end else if (i_add) begin
         acc_r <= acc_r + val_ext_s;
      end else if (i_sub) begin
         acc_r <= acc_r - val_ext_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   // sign-extend accumulator and bias, then apply the activation
   always_comb begin
      acc_wide_s  = {{(FN_W-ACC_BIT){acc_r[ACC_BIT-1]}}, acc_r};
      bias_wide_s = {{(FN_W-NUM_BIT-1){i_bias[NUM_BIT]}}, i_bias};
      act_wide_s  = sat_relu(acc_wide_s, bias_wide_s, SHIFT, NUM_BIT);
      o_act       = act_wide_s[NUM_BIT-1:0];
   end

   // upper bits are always zero after saturation
   assign unused_hi_s = ^act_wide_s[FN_W-1:NUM_BIT];

endmodule

// File: rtl/mvm_acc_act.sv
// Accumulates NUM_TERM signed MVM passes per lane, then applies
// bias/ReLU/shift/saturate and offers the vector on valid/ready.
module mvm_acc_act
   import mvm_acc_act_pkg::*;
#(
   parameter int NUM_BIT  = NUM_BIT_DEF,
   parameter int DIM      = DIM_DEF,
   parameter int NUM_TERM = 4,
   parameter int SHIFT    = 0,
   parameter int ACC_BIT  = NUM_BIT + $clog2(NUM_TERM) + 2
) (
   input  logic                         i_clk_acc,
   input  logic                         i_rst_acc,
   input  logic                         i_ismvm,
   input  logic [DIM-1:0][NUM_BIT-1:0]  i_wx_result,
   input  logic                         i_w_neg,
   input  logic [DIM-1:0][NUM_BIT:0]    i_bias,
   input  logic                         i_clear,
   input  logic                         i_ready,
   output logic                         o_valid,
   output logic [DIM-1:0][NUM_BIT-1:0]  o_y,
   output logic                         o_busy,
   output logic                         o_overrun
);

   localparam int CNT_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;
   localparam logic [CNT_W-1:0] TERM_LAST = CNT_W'(NUM_TERM - 1);

   state_e                      state_r;
   state_e                      state_nx_s;
   logic [CNT_W-1:0]            term_cnt_r;
   logic [CNT_W-1:0]            term_cnt_nx_s;
   logic                        ismvm_d_r;
   logic                        done_s;
   logic                        acc_add_s;
   logic                        acc_sub_s;
   logic                        acc_clr_s;
   logic                        y_load_s;
   logic                        valid_nx_s;
   logic                        overrun_set_s;
   logic [DIM-1:0][NUM_BIT-1:0] act_s;

   // falling edge of the MVM busy flag marks a finished pass
   assign done_s = ismvm_d_r & ~i_ismvm;

   // next-state, lane controls and handshake; frame abort overrides all
   always_comb begin
      state_nx_s    = state_r;
      term_cnt_nx_s = term_cnt_r;
      acc_add_s     = 1'b0;
      acc_sub_s     = 1'b0;
      acc_clr_s     = 1'b0;
      y_load_s      = 1'b0;
      valid_nx_s    = o_valid;
      overrun_set_s = 1'b0;
      case (state_r)
         ACCUM: begin
            if (done_s) begin
               acc_add_s = ~i_w_neg;
               acc_sub_s = i_w_neg;
               if (term_cnt_r == TERM_LAST) begin
                  term_cnt_nx_s = '0;
                  state_nx_s    = ACT;
               end else begin
                  term_cnt_nx_s = term_cnt_r + CNT_W'(1);
               end
            end else begin
               state_nx_s = ACCUM;
            end
         end
         ACT: begin
            y_load_s      = 1'b1;
            valid_nx_s    = 1'b1;
            overrun_set_s = done_s;
            state_nx_s    = HOLD;
         end
         HOLD: begin
            overrun_set_s = done_s;
            if (i_ready && o_valid) begin
               valid_nx_s = 1'b0;
               acc_clr_s  = 1'b1;
               state_nx_s = ACCUM;
            end else begin
               state_nx_s = HOLD;
            end
         end
         default: begin
            state_nx_s = ACCUM;
         end
      endcase
      if (i_clear) begin
         acc_add_s     = 1'b0;
         acc_sub_s     = 1'b0;
         acc_clr_s     = 1'b1;
         y_load_s      = 1'b0;
         valid_nx_s    = 1'b0;
         overrun_set_s = 1'b0;
         term_cnt_nx_s = '0;
         state_nx_s    = ACCUM;
      end else begin
         acc_clr_s = acc_clr_s;
      end
   end

   // control registers and registered outputs
   always_ff @(posedge i_clk_acc) begin
      if (i_rst_acc) begin
         state_r    <= ACCUM;
         term_cnt_r <= '0;
         ismvm_d_r  <= 1'b0;
         o_valid    <= 1'b0;
         o_busy     <= 1'b0;
         o_y        <= '0;
         o_overrun  <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         term_cnt_r <= term_cnt_nx_s;
         ismvm_d_r  <= i_ismvm;
         o_valid    <= valid_nx_s;
         o_busy     <= (state_nx_s != ACCUM);
         if (i_clear) begin
            o_y       <= '0;
            o_overrun <= 1'b0;
         end else begin
            o_y       <= y_load_s ? act_s : o_y;
            o_overrun <= o_overrun | overrun_set_s;
         end
      end
   end

   for (genvar g = 0; g < DIM; g++) begin : g_lane
      mvm_acc_act_acc_lane #(
         .NUM_BIT (NUM_BIT),
         .ACC_BIT (ACC_BIT),
         .SHIFT   (SHIFT)
      ) u_lane (
         .i_clk_acc (i_clk_acc),
         .i_rst_acc (i_rst_acc),
         .i_add     (acc_add_s),
         .i_sub     (acc_sub_s),
         .i_clr     (acc_clr_s),
         .i_val     (i_wx_result[g]),
         .i_bias    (i_bias[g]),
         .o_act     (act_s[g])
      );
   end

endmodule

// File: tb/tb_mvm_acc_act.sv
// Bench for mvm_acc_act: two instances (SHIFT=0 and SHIFT=1, NUM_TERM=2)
// share stimulus; a lane model pushes expected vectors, a monitor pops them.
module tb_mvm_acc_act;

   localparam int NB = 4;
   localparam int D  = 4;
   localparam int NT = 2;

   typedef logic [D-1:0][NB-1:0] vec_t;

   logic clk = 1'b0;
   logic rst, ismvm, w_neg, clear, ready;
   vec_t wx;
   logic [D-1:0][NB:0] bias;
   logic valid0, busy0, ovr0, valid1, busy1, ovr1;
   vec_t y0, y1;

   int checks = 0;
   int errors = 0;
   int macc[D];
   int mterm;
   int bias_m[D];
   vec_t exp_q0[$];
   vec_t exp_q1[$];
   vec_t e0, e1;

   always #5 clk = ~clk;

   mvm_acc_act #(.NUM_BIT(NB), .DIM(D), .NUM_TERM(NT), .SHIFT(0)) dut0 (
      .i_clk_acc(clk), .i_rst_acc(rst), .i_ismvm(ismvm), .i_wx_result(wx),
      .i_w_neg(w_neg), .i_bias(bias), .i_clear(clear), .i_ready(ready),
      .o_valid(valid0), .o_y(y0), .o_busy(busy0), .o_overrun(ovr0));

   mvm_acc_act #(.NUM_BIT(NB), .DIM(D), .NUM_TERM(NT), .SHIFT(1)) dut1 (
      .i_clk_acc(clk), .i_rst_acc(rst), .i_ismvm(ismvm), .i_wx_result(wx),
      .i_w_neg(w_neg), .i_bias(bias), .i_clear(clear), .i_ready(ready),
      .o_valid(valid1), .o_y(y1), .o_busy(busy1), .o_overrun(ovr1));

   function automatic vec_t pk(input int a, input int b, input int c, input int d);
      vec_t r;
      r[0] = a[3:0]; r[1] = b[3:0]; r[2] = c[3:0]; r[3] = d[3:0];
      return r;
   endfunction

   function automatic vec_t model_eval(input int sh);
      vec_t r;
      int s;
      for (int i = 0; i < D; i++) begin
         s = macc[i] + bias_m[i];
         if (s < 0) s = 0;
         else s = s >>> sh;
         if (s > 15) s = 15;
         r[i] = s[3:0];
      end
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < D; i++) macc[i] = 0;
      mterm = 0;
   endtask

   task automatic set_bias(input int b0, input int b1, input int b2, input int b3);
      bias_m[0] = b0; bias_m[1] = b1; bias_m[2] = b2; bias_m[3] = b3;
      for (int i = 0; i < D; i++) bias[i] = bias_m[i][4:0];
   endtask

   // busy high for two cycles, then final counts in the first low cycle;
   // returns one cycle after that cycle (ACT cycle when a frame completes)
   task automatic do_pass(input vec_t v, input logic neg, input bit drop);
      @(posedge clk); #1;
      ismvm = 1'b1; wx = vec_t'($urandom); w_neg = 1'($urandom);
      @(posedge clk); #1;
      @(posedge clk); #1;
      ismvm = 1'b0; wx = v; w_neg = neg;
      @(posedge clk); #1;
      wx = vec_t'($urandom); w_neg = 1'($urandom);
      if (!drop) begin
         for (int i = 0; i < D; i++) macc[i] += neg ? -int'(v[i]) : int'(v[i]);
         mterm++;
         if (mterm == NT) begin
            exp_q0.push_back(model_eval(0));
            exp_q1.push_back(model_eval(1));
            model_clear();
         end
      end
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
   endtask

   // scoreboard: every accepted vector must match the model's next entry
   always @(negedge clk) begin
      if (valid0 && ready) begin
         checks++;
         if (exp_q0.size() == 0) begin
            errors++; $display("FAIL sb_y0: got %h, required none pending", y0);
         end else begin
            e0 = exp_q0.pop_front();
            if (y0 !== e0) begin errors++; $display("FAIL sb_y0: got %h, required %h", y0, e0); end
         end
      end
      if (valid1 && ready) begin
         checks++;
         if (exp_q1.size() == 0) begin
            errors++; $display("FAIL sb_y1: got %h, required none pending", y1);
         end else begin
            e1 = exp_q1.pop_front();
            if (y1 !== e1) begin errors++; $display("FAIL sb_y1: got %h, required %h", y1, e1); end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; ismvm = 1'b0; clear = 1'b0; ready = 1'b0; w_neg = 1'b0; wx = '0;
      set_bias(0, 0, 0, 0);
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({valid0, busy0, ovr0, y0, valid1, busy1, ovr1, y1} !== '0) begin
            errors++;
            $display("FAIL reset_idle: cyc %0d v=%b b=%b o=%b y=%h, required all 0", c, valid0, busy0, ovr0, y0);
         end
      end
   endtask

   task automatic test_pos_sat();
      ready = 1'b0;
      do_pass(pk(3, 5, 0, 15), 1'b0, 1'b0);
      checks++;
      if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
         errors++; $display("FAIL pos_mid_frame: valid=%b busy=%b, required 0 0", valid0, busy0);
      end
      do_pass(pk(2, 1, 0, 15), 1'b0, 1'b0);
      checks++;
      if (valid0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++; $display("FAIL pos_act_cycle: valid=%b busy=%b, required 0 1", valid0, busy0);
      end
      @(posedge clk); #1;
      checks++;
      if (valid0 !== 1'b1 || y0 !== pk(5, 6, 0, 15)) begin
         errors++; $display("FAIL pos_sat: valid=%b y=%h, required 1 %h", valid0, y0, pk(5, 6, 0, 15));
      end
      pulse_ready();
      checks++;
      if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
         errors++; $display("FAIL pos_release: valid=%b busy=%b, required 0 0", valid0, busy0);
      end
   endtask

   task automatic test_neg_bias();
      set_bias(0, -1, 2, 0);
      do_pass(pk(3, 7, 1, 0), 1'b0, 1'b0);
      do_pass(pk(5, 2, 0, 0), 1'b1, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (valid0 !== 1'b1 || y0 !== pk(0, 4, 3, 0)) begin
         errors++; $display("FAIL neg_bias: valid=%b y=%h, required 1 %h", valid0, y0, pk(0, 4, 3, 0));
      end
      pulse_ready();
      set_bias(0, 0, 0, 0);
   endtask

   task automatic test_shift();
      do_pass(pk(4, 1, 8, 15), 1'b0, 1'b0);
      do_pass(pk(5, 1, 8, 15), 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (valid1 !== 1'b1 || y1 !== pk(4, 1, 8, 15)) begin
         errors++; $display("FAIL shift1: valid=%b y=%h, required 1 %h", valid1, y1, pk(4, 1, 8, 15));
      end
      pulse_ready();
   endtask

   task automatic test_backpressure();
      ready = 1'b0;
      do_pass(pk(6, 0, 3, 12), 1'b0, 1'b0);
      do_pass(pk(1, 4, 3, 12), 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (valid0 !== 1'b1 || y0 !== pk(7, 4, 6, 15)) begin
         errors++; $display("FAIL bp_first: valid=%b y=%h, required 1 %h", valid0, y0, pk(7, 4, 6, 15));
      end
      do_pass(pk(9, 9, 9, 9), 1'b0, 1'b1);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checks++;
         if (valid0 !== 1'b1 || y0 !== pk(7, 4, 6, 15) || ovr0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: valid=%b y=%h ovr=%b, required 1 %h 1", valid0, y0, ovr0, pk(7, 4, 6, 15));
         end
      end
      pulse_ready();
      do_pass(pk(1, 1, 1, 1), 1'b0, 1'b0);
      do_pass(pk(1, 1, 1, 1), 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (valid0 !== 1'b1 || y0 !== pk(2, 2, 2, 2) || ovr0 !== 1'b1) begin
         errors++; $display("FAIL bp_restart: valid=%b y=%h ovr=%b, required 1 %h 1", valid0, y0, ovr0, pk(2, 2, 2, 2));
      end
      pulse_ready();
   endtask

   task automatic test_clear();
      ready = 1'b1;
      do_pass(pk(7, 7, 7, 7), 1'b0, 1'b0);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_clear();
      checks++;
      if (ovr0 !== 1'b0 || ovr1 !== 1'b0 || valid0 !== 1'b0) begin
         errors++; $display("FAIL clear_flags: ovr=%b/%b valid=%b, required 0/0 0", ovr0, ovr1, valid0);
      end
      do_pass(pk(1, 2, 3, 4), 1'b0, 1'b0);
      do_pass(pk(1, 2, 3, 4), 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (valid0 !== 1'b1 || y0 !== pk(2, 4, 6, 8) || ovr0 !== 1'b0) begin
         errors++; $display("FAIL clear_result: valid=%b y=%h ovr=%b, required 1 %h 0", valid0, y0, ovr0, pk(2, 4, 6, 8));
      end
      @(posedge clk); #1;
      checks++;
      if (valid0 !== 1'b0) begin
         errors++; $display("FAIL clear_pulse: valid=%b, required 0", valid0);
      end
   endtask

   task automatic test_midop_reset();
      ready = 1'b0;
      do_pass(pk(5, 5, 5, 5), 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      checks++;
      if ({valid0, busy0, ovr0, y0} !== '0) begin
         errors++; $display("FAIL midop_reset: v=%b b=%b o=%b y=%h, required all 0", valid0, busy0, ovr0, y0);
      end
      do_pass(pk(1, 1, 1, 1), 1'b0, 1'b0);
      do_pass(pk(1, 1, 1, 1), 1'b0, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (valid0 !== 1'b1 || y0 !== pk(2, 2, 2, 2)) begin
         errors++; $display("FAIL midop_result: valid=%b y=%h, required 1 %h", valid0, y0, pk(2, 2, 2, 2));
      end
      pulse_ready();
   endtask

   initial begin
      test_reset();
      test_pos_sat();
      test_neg_bias();
      test_shift();
      test_backpressure();
      test_clear();
      test_midop_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++; $display("FAIL sb_drain: pending %0d/%0d, required 0/0", exp_q0.size(), exp_q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
